motor_drive_ctrl: RTL
=====================

Name: motor_drive_ctrl

Overview:
- Downstream consumer of the Bluetooth command parser's man_motor_state.
- Decodes the 3-bit drive command into per-wheel direction for a dual H-bridge (L298N-style IN1/IN2/EN per side).
- Generates ramped PWM enables and inserts a coast dead-time on every direction reversal.
- In AUTO it follows a second command input driven by the HuskyLens arrow path.

Parameters:
- PWM_PERIOD, 5000: PWM counter period in clk cycles (20 kHz at 100 MHz).
- DUTY_START, 2000: duty applied on leaving IDLE/DEAD; must be <= DUTY_MAX.
- DUTY_MAX, 4000: duty ceiling; must be <= PWM_PERIOD.
- RAMP_STEP, 100: duty increment per ramp tick.
- RAMP_TICKS, 100000: clk cycles between ramp increments.
- DEAD_CYCLES, 100000: coast cycles on direction reversal; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- man_motor_state  in  3  command from the parser: 000 STOP, 001 FWD, 010 BWD, 011 LEFT, 100 RIGHT, 110 AUTO
- auto_motor_state  in  3  command used while man_motor_state==AUTO; same encoding
- motor_l_in1, motor_l_in2  out  1 each  left bridge direction
- motor_r_in1, motor_r_in2  out  1 each  right bridge direction
- motor_l_en, motor_r_en  out  1 each  PWM enables
- moving  out  1  high in RUN state
- duty_level  out  clog2(PWM_PERIOD+1)  currently active duty, for LEDs/debug

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM=IDLE; counters 0; cmd_q=STOP.
- Command resolve:
  - effective = (man==110) ? auto : man.
  - If effective is 101, 110 or 111, it resolves to STOP. An AUTO command arriving on the auto input is also STOP.
  - Registered into cmd_q each cycle: 1-cycle latency.
- Wheel direction per cmd_q:
  - FWD: L+, R+.
  - BWD: L-, R-.
  - LEFT: L-, R+.
  - RIGHT: L+, R-.
  - STOP: off.
  - "+" drives in1=1,in2=0. "-" drives in1=0,in2=1. "off" drives both 0.
- FSM states: IDLE, DEAD, RUN. Transitions are evaluated on cmd_q; outputs are registered, so pins change 2 cycles after an input change.
  - IDLE: pins and en = 0, duty=0.
    - cmd_q != STOP -> RUN with the new directions and duty=DUTY_START.
  - RUN, cmd_q==STOP -> IDLE. en forced 0 and duty=0 on the transition edge, not at the period boundary.
  - RUN, cmd_q non-STOP with either wheel's direction different from the applied direction -> DEAD.
    - On entry: pins and en = 0, duty=0, dead counter loaded.
  - RUN, same directions -> stay. The ramp continues uninterrupted.
  - DEAD: counts DEAD_CYCLES cycles, then:
    - cmd_q (sampled at expiry) STOP -> IDLE.
    - Otherwise -> RUN with cmd_q's directions and duty=DUTY_START.
    - cmd_q changing during DEAD does not restart the count.
- Ramp (RUN only):
  - Tick counter counts to RAMP_TICKS-1 and wraps.
  - On each wrap, duty = min(duty+RAMP_STEP, DUTY_MAX). Saturates, never wraps.
  - The tick counter clears on entry to RUN.
- PWM:
  - pwm_cnt runs 0..PWM_PERIOD-1 continuously and wraps.
  - duty_active <= duty when pwm_cnt==PWM_PERIOD-1, so a duty change takes effect at the next period start.
  - en = RUN && (pwm_cnt < duty_active), registered. Both wheels share the same duty.
  - Forced-off cases (STOP, DEAD entry) bypass the latch: duty_active cleared immediately.
- duty_level = duty_active; moving = (state==RUN).
- Direction pins never switch from + to - without passing through DEAD. No cycle may drive in1=in2=1.

Decomposition:
- Shared package/header holds:
  - Command encodings (MAN_STOP..AUTO, identical values to the parser).
  - Wheel-direction constants DIR_OFF/DIR_FWD/DIR_REV.
  - FSM state encodings.
- One natural sub-module: pwm_gen (counter, period-boundary duty latch, force-off input, en output). Instantiate it once and share its output across both enables.

Test Plan:
Bench parameters: PWM_PERIOD=10, DUTY_START=4, DUTY_MAX=8, RAMP_STEP=2, RAMP_TICKS=20, DEAD_CYCLES=5.
- Reset, then man=001 -> 2 cycles later: l_in1=r_in1=1, in2s=0, moving=1. en high 4 of 10 cycles from next period start. Duty goes 6, 8, 8 at 20-cycle ticks.
- RUN FWD, man=010 -> all pins and en 0 for exactly 5 cycles, then l_in2=r_in2=1 and duty restarts at 4. No cycle with in1 and in2 both high.
- RUN FWD at duty 8, man=000 -> en, pins, duty_level and moving all 0 two cycles later, mid-period.
- man=110 with auto=011 -> l_in2=1, r_in1=1. Then auto=110 or auto=101 -> treated as STOP, goes to IDLE.
- man=111 from IDLE -> stays IDLE. RUN FWD then man=001->100 -> DEAD inserted (left unchanged, right reverses).
- Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately. After release with man=001 held -> RUN at duty 4 after 2 cycles.

Source files
------------

// File: rtl/motor_drive_ctrl_pkg.sv
// Shared encodings for the motor drive controller: parser command codes,
// per-wheel direction codes, FSM states and the command-decoding helpers.
package motor_drive_ctrl_pkg;

  // Command codes, identical to the values the Bluetooth command parser emits
  typedef enum logic [2:0] {
    MAN_STOP  = 3'b000,
    MAN_FWD   = 3'b001,
    MAN_BWD   = 3'b010,
    MAN_LEFT  = 3'b011,
    MAN_RIGHT = 3'b100,
    MAN_AUTO  = 3'b110
  } cmd_e;

  // One-hot style wheel direction: bit 0 drives IN1, bit 1 drives IN2, never both
  typedef enum logic [1:0] {
    DIR_OFF = 2'b00,
    DIR_FWD = 2'b01,
    DIR_REV = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DEAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  // Picks the manual or auto command and folds every code that is not a
  // drive command (101, 110, 111, including AUTO on the auto input) into STOP
  function automatic cmd_e resolveCmd(input logic [2:0] manCmd, input logic [2:0] autoCmd);
    logic [2:0] effective;
    effective = (manCmd == MAN_AUTO) ? autoCmd : manCmd;
    case (effective)
      MAN_FWD:   resolveCmd = MAN_FWD;
      MAN_BWD:   resolveCmd = MAN_BWD;
      MAN_LEFT:  resolveCmd = MAN_LEFT;
      MAN_RIGHT: resolveCmd = MAN_RIGHT;
      default:   resolveCmd = MAN_STOP;
    endcase
  endfunction

  // Left wheel turns backwards for BWD and for a LEFT pivot
  function automatic dir_e leftDir(input cmd_e cmd);
    case (cmd)
      MAN_FWD:   leftDir = DIR_FWD;
      MAN_BWD:   leftDir = DIR_REV;
      MAN_LEFT:  leftDir = DIR_REV;
      MAN_RIGHT: leftDir = DIR_FWD;
      default:   leftDir = DIR_OFF;
    endcase
  endfunction

  // Right wheel turns backwards for BWD and for a RIGHT pivot
  function automatic dir_e rightDir(input cmd_e cmd);
    case (cmd)
      MAN_FWD:   rightDir = DIR_FWD;
      MAN_BWD:   rightDir = DIR_REV;
      MAN_LEFT:  rightDir = DIR_FWD;
      MAN_RIGHT: rightDir = DIR_REV;
      default:   rightDir = DIR_OFF;
    endcase
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// Free-running PWM generator shared by both wheels. The duty is latched only
// at the end of a period so the pulse shape never tears mid-period, except
// when the controller forces the output off, which clears it immediately.
module motor_drive_ctrl_pwm_gen #(
  parameter int PWM_PERIOD = 5000,
  parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_forceOff,
  input  logic [DW-1:0] i_duty,
  output logic          o_en,
  output logic [DW-1:0] o_dutyActive
);

  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_PERIOD - 1);

  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_dutyActive;
  logic          r_en;
  logic [DW-1:0] w_cntNext;
  logic [DW-1:0] w_dutyActiveNext;

  // Next counter value and next latched duty (force-off beats the period latch)
  always_comb begin
    w_cntNext        = (r_cnt == CNT_LAST) ? '0 : r_cnt + DW'(1);
    w_dutyActiveNext = r_dutyActive;
    if (i_forceOff) begin
      w_dutyActiveNext = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_dutyActiveNext = i_duty;
    end
  end

  // Enable is computed from the next counter/duty so it lines up with them
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt        <= '0;
      r_dutyActive <= '0;
      r_en         <= 1'b0;
    end else begin
      r_cnt        <= w_cntNext;
      r_dutyActive <= w_dutyActiveNext;
      r_en         <= i_run && (w_cntNext < w_dutyActiveNext);
    end
  end

  assign o_en         = r_en;
  assign o_dutyActive = r_dutyActive;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Dual H-bridge drive controller: decodes the parser (or HuskyLens auto)
// command into wheel directions, ramps a shared PWM duty while running and
// inserts a coast interval whenever a wheel has to change direction.
module motor_drive_ctrl
  import motor_drive_ctrl_pkg::*;
#(
  parameter int PWM_PERIOD  = 5000,
  parameter int DUTY_START  = 2000,
  parameter int DUTY_MAX    = 4000,
  parameter int RAMP_STEP   = 100,
  parameter int RAMP_TICKS  = 100000,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2:0]                         man_motor_state,
  input  logic [2:0]                         auto_motor_state,
  output logic                               motor_l_in1,
  output logic                               motor_l_in2,
  output logic                               motor_r_in1,
  output logic                               motor_r_in2,
  output logic                               motor_l_en,
  output logic                               motor_r_en,
  output logic                               moving,
  output logic [$clog2(PWM_PERIOD+1)-1:0]    duty_level
);

  localparam int DW  = $clog2(PWM_PERIOD + 1);
  localparam int TW  = $clog2(RAMP_TICKS + 1);
  localparam int DCW = $clog2(DEAD_CYCLES + 1);

  localparam logic [DW-1:0]  DUTY_START_W = DW'(DUTY_START);
  localparam logic [DW-1:0]  DUTY_MAX_W   = DW'(DUTY_MAX);
  localparam logic [TW-1:0]  TICK_LAST    = TW'(RAMP_TICKS - 1);
  localparam logic [DCW-1:0] DEAD_LOAD    = DCW'(DEAD_CYCLES - 1);

  cmd_e           r_cmdQ;
  state_e         r_state;
  dir_e           r_dirL;
  dir_e           r_dirR;
  logic [DW-1:0]  r_duty;
  logic [TW-1:0]  r_tick;
  logic [DCW-1:0] r_dead;

  state_e         w_stateNext;
  dir_e           w_dirLNext;
  dir_e           w_dirRNext;
  dir_e           w_cmdDirL;
  dir_e           w_cmdDirR;
  logic [DW-1:0]  w_dutyNext;
  logic [DW-1:0]  w_dutyRamp;
  logic [TW-1:0]  w_tickNext;
  logic [DCW-1:0] w_deadNext;
  logic           w_en;
  logic [DW-1:0]  w_dutyActive;

  // Resolve manual/auto selection once per cycle; the FSM only sees this copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmdQ <= MAN_STOP;
    end else begin
      r_cmdQ <= resolveCmd(man_motor_state, auto_motor_state);
    end
  end

  // Next state, applied directions, ramped duty and the tick/dead counters
  always_comb begin
    w_stateNext = r_state;
    w_dirLNext  = r_dirL;
    w_dirRNext  = r_dirR;
    w_dutyNext  = r_duty;
    w_tickNext  = r_tick;
    w_deadNext  = r_dead;
    w_cmdDirL   = leftDir(r_cmdQ);
    w_cmdDirR   = rightDir(r_cmdQ);
    w_dutyRamp  = (32'(r_duty) + 32'(RAMP_STEP) >= 32'(DUTY_MAX)) ? DUTY_MAX_W
                                                                  : r_duty + DW'(RAMP_STEP);
    case (r_state)
      ST_IDLE: begin
        w_dirLNext = DIR_OFF;
        w_dirRNext = DIR_OFF;
        w_dutyNext = '0;
        w_tickNext = '0;
        if (r_cmdQ != MAN_STOP) begin
          w_stateNext = ST_RUN;
          w_dirLNext  = w_cmdDirL;
          w_dirRNext  = w_cmdDirR;
          w_dutyNext  = DUTY_START_W;
        end
      end
      ST_RUN: begin
        if (r_cmdQ == MAN_STOP) begin
          w_stateNext = ST_IDLE;
          w_dirLNext  = DIR_OFF;
          w_dirRNext  = DIR_OFF;
          w_dutyNext  = '0;
          w_tickNext  = '0;
        end else if ((w_cmdDirL != r_dirL) || (w_cmdDirR != r_dirR)) begin
          w_stateNext = ST_DEAD;
          w_dirLNext  = DIR_OFF;
          w_dirRNext  = DIR_OFF;
          w_dutyNext  = '0;
          w_tickNext  = '0;
          w_deadNext  = DEAD_LOAD;
        end else if (r_tick == TICK_LAST) begin
          w_tickNext = '0;
          w_dutyNext = w_dutyRamp;
        end else begin
          w_tickNext = r_tick + TW'(1);
        end
      end
      ST_DEAD: begin
        w_dirLNext = DIR_OFF;
        w_dirRNext = DIR_OFF;
        w_dutyNext = '0;
        w_tickNext = '0;
        if (r_dead == '0) begin
          if (r_cmdQ == MAN_STOP) begin
            w_stateNext = ST_IDLE;
          end else begin
            w_stateNext = ST_RUN;
            w_dirLNext  = w_cmdDirL;
            w_dirRNext  = w_cmdDirR;
            w_dutyNext  = DUTY_START_W;
          end
        end else begin
          w_deadNext = r_dead - DCW'(1);
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_dirLNext  = DIR_OFF;
        w_dirRNext  = DIR_OFF;
        w_dutyNext  = '0;
        w_tickNext  = '0;
        w_deadNext  = '0;
      end
    endcase
  end

  // Register the FSM so the bridge pins come straight from flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_dirL  <= DIR_OFF;
      r_dirR  <= DIR_OFF;
      r_duty  <= '0;
      r_tick  <= '0;
      r_dead  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_dirL  <= w_dirLNext;
      r_dirR  <= w_dirRNext;
      r_duty  <= w_dutyNext;
      r_tick  <= w_tickNext;
      r_dead  <= w_deadNext;
    end
  end

  motor_drive_ctrl_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD),
    .DW         (DW)
  ) u_pwmGen (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_run        (w_stateNext == ST_RUN),
    .i_forceOff   (w_stateNext != ST_RUN),
    .i_duty       (w_dutyNext),
    .o_en         (w_en),
    .o_dutyActive (w_dutyActive)
  );

  assign motor_l_in1 = (r_dirL == DIR_FWD);
  assign motor_l_in2 = (r_dirL == DIR_REV);
  assign motor_r_in1 = (r_dirR == DIR_FWD);
  assign motor_r_in2 = (r_dirR == DIR_REV);
  assign motor_l_en  = w_en;
  assign motor_r_en  = w_en;
  assign moving      = (r_state == ST_RUN);
  assign duty_level  = w_dutyActive;

endmodule
